// File: rtl/sm83_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_bus_ctrl
//  Description : SM83 CPU-side bus initiator. Turns byte/word (little-endian)
//                load/store requests into one-byte-per-M-cycle transfers on a
//                single-port memory interface and returns load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_bus_ctrl #(
    parameter int T_PER_M = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_word,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_busy,
    output logic [15:0] o_mem_r_addr,
    output logic [15:0] o_mem_w_addr,
    output logic [7:0]  o_mem_w_data,
    output logic        o_mem_wen,
    input  logic [7:0]  i_mem_r_data
);

    localparam int              C_TW     = $clog2(T_PER_M);
    localparam logic [C_TW-1:0] C_T_LAST = C_TW'(T_PER_M - 1);
    localparam logic [C_TW-1:0] C_T_ONE  = C_TW'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    logic [C_TW-1:0]   r_tcnt;
    logic              r_byte_idx;
    logic [15:0]       r_base;
    logic              r_we;
    logic              r_word;
    logic [15:0]       r_wdata;
    logic [7:0]        r_rd_lo;
    logic              r_rsp_valid;
    logic [15:0]       r_rsp_rdata;

    logic              w_end_m;
    logic              w_last_byte;
    logic              w_accept;
    logic [15:0]       w_addr;

    // Last T-state of an M-cycle, and whether the byte in flight is the final one
    assign w_end_m     = (r_state == S_ACCESS) && (r_tcnt == C_T_LAST);
    assign w_last_byte = !r_word || r_byte_idx;

    // Ready in IDLE, or at the very end of the final byte so the next access starts without a gap
    assign o_req_ready = (r_state == S_IDLE) || (w_end_m && w_last_byte);
    assign w_accept    = i_req_valid && o_req_ready;

    // Byte address wraps naturally at 16 bits; held in IDLE because byte_idx and base hold
    assign w_addr       = r_base + {15'd0, r_byte_idx};
    assign o_mem_r_addr = w_addr;
    assign o_mem_w_addr = w_addr;
    assign o_mem_w_data = r_byte_idx ? r_wdata[15:8] : r_wdata[7:0];

    // Write strobe is a decode of reset-cleared state, so it falls as soon as rst_n asserts
    assign o_mem_wen    = w_end_m && r_we;

    assign o_busy       = (r_state == S_ACCESS);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;

    // Sequencer: step T-states and bytes, gather load data, pulse the response, accept requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_byte_idx  <= 1'b0;
            r_base      <= '0;
            r_we        <= 1'b0;
            r_word      <= 1'b0;
            r_wdata     <= '0;
            r_rd_lo     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;

            if (r_state == S_ACCESS) begin
                if (r_tcnt != C_T_LAST) begin
                    r_tcnt <= r_tcnt + C_T_ONE;
                end else if (!w_last_byte) begin
                    // First byte of a word done: keep the low byte and move to the high byte
                    r_tcnt     <= '0;
                    r_byte_idx <= 1'b1;
                    if (!r_we) begin
                        r_rd_lo <= i_mem_r_data;
                    end
                end else begin
                    // Final byte done: respond; loads update the result, stores leave it alone
                    r_rsp_valid <= 1'b1;
                    if (!r_we) begin
                        r_rsp_rdata <= r_word ? {i_mem_r_data, r_rd_lo}
                                              : {8'h00, i_mem_r_data};
                    end
                    r_state <= S_IDLE;
                    r_tcnt  <= '0;
                end
            end

            // Acceptance overrides the drop to IDLE, giving a gapless back-to-back start
            if (w_accept) begin
                r_state    <= S_ACCESS;
                r_tcnt     <= '0;
                r_byte_idx <= 1'b0;
                r_base     <= i_req_addr;
                r_we       <= i_req_we;
                r_word     <= i_req_word;
                r_wdata    <= i_req_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sm83_bus_ctrl.md
Name: sm83_bus_ctrl

Overview:
CPU-side bus initiator for the SM83 core. It accepts byte or word (16-bit, little-endian) load/store requests from the core's execution sequencer. It drives the single-port memory interface (read address, write address, write data, write enable) and returns read data to the core. Each byte transfer occupies exactly one M-cycle of T_PER_M clocks, matching Game Boy bus timing.

Parameters:
T_PER_M, 4, clocks per M-cycle (one byte transfer); legal range >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  core request valid
req_ready  output  1  controller can accept a request this clock
req_we  input  1  1 = store, 0 = load
req_word  input  1  1 = 16-bit access (two bytes), 0 = byte access
req_addr  input  16  access address (addr_t)
req_wdata  input  16  store data; byte access uses [7:0]
rsp_valid  output  1  one-clock pulse: access complete
rsp_rdata  output  16  load result; byte load zero-extends
busy  output  1  access in progress
mem_r_addr  output  16  memory read address
mem_w_addr  output  16  memory write address
mem_w_data  output  8  memory write data (data_t)
mem_wen  output  1  memory write enable, written on posedge
mem_r_data  input  8  memory read data, combinational from mem_r_addr

Behaviour:
- Reset (async): state IDLE, tcnt=0, byte_idx=0. All outputs 0 except req_ready=1.
- States: IDLE, ACCESS. tcnt counts 0..T_PER_M-1 within the M-cycle. byte_idx is 0 or 1.
- Handshake: transfer occurs when req_valid && req_ready at a posedge. Addr, we, word and wdata are captured at that edge. Later changes on req_* are ignored until the next acceptance.
- req_ready=1 in IDLE. It is also 1 in ACCESS when tcnt==T_PER_M-1 and the current byte is the last byte (pipelined accept). Otherwise it is 0.
- On acceptance: state=ACCESS, tcnt=0, byte_idx=0 from the next clock.
- During ACCESS: mem_r_addr and mem_w_addr = base+byte_idx, 16-bit wrap (0xFFFF+1 = 0x0000). Both are stable for the whole M-cycle.
- mem_w_data = wdata[7:0] for byte_idx 0 and wdata[15:8] for byte_idx 1. It is stable for the whole M-cycle.
- Store: mem_wen=1 only in the tcnt==T_PER_M-1 clock, for exactly one clock per byte.
- Load: mem_wen=0 throughout. mem_r_data is sampled at the edge ending tcnt==T_PER_M-1. byte_idx 0 goes to rdata[7:0], byte_idx 1 goes to rdata[15:8].
- At the end of each M-cycle:
  - If the byte is not the last: byte_idx++ and tcnt=0.
  - Else, if a new request is accepted: start it immediately, with no idle clock.
  - Else: go to IDLE.
- rsp_valid: 1 for the single clock after the last M-cycle ends. This applies to both loads and stores.
- rsp_rdata: updated together with rsp_valid for loads, and held until the next load completes. Stores leave it unchanged. Byte loads set [15:8]=0.
- Latency, with acceptance edge = cycle 0:
  - Byte: rsp_valid in cycle T_PER_M+1.
  - Word: rsp_valid in cycle 2*T_PER_M+1.
- Back-to-back: the rsp_valid of the earlier access coincides with tcnt=0 of the next access.
- busy=1 whenever state==ACCESS.
- In IDLE: mem_wen=0, and addresses and w_data hold their last values.
- Reset mid-operation: abort immediately.
  - mem_wen drops asynchronously.
  - No rsp_valid is issued.
  - No remaining bytes are written.
  - The controller returns to the reset state.

Test Plan:
- Byte load: memory preloaded mem[0x0001]=0x01; accept load byte addr 0x0001 at cycle 0 -> mem_r_addr=0x0001 for cycles 1-4; rsp_valid only in cycle 5 with rsp_rdata=0x0001; mem_wen never high.
- Word load: mem[0x0000]=0x00, mem[0x0001]=0x01; load word addr 0x0000 -> mem_r_addr=0x0000 for cycles 1-4, then 0x0001 for cycles 5-8; rsp_valid in cycle 9 with rsp_rdata=0x0100.
- Byte store: addr 0x0010, wdata 0x005A, prior rsp_rdata=0x0100 -> mem_wen high only in cycle 4 with mem_w_addr=0x0010, mem_w_data=0x5A; rsp_valid in cycle 5; rsp_rdata stays 0x0100; a byte load of 0x0010 then returns 0x005A.
- Word store with wrap: addr 0xFFFF, wdata 0xBEEF -> mem_wen pulses in cycles 4 and 8; first pulse writes 0xEF at 0xFFFF, second writes 0xBE at 0x0000; req_ready=0 in cycles 1-7 and 1 in cycle 8.
- Back-to-back: req_valid held high with byte load 0x0001 then byte load 0x0000 -> second accepted at the cycle-4 edge; its mem_r_addr=0x0000 from cycle 5; rsp_valid pulses in cycles 5 and 9 with 0x0001 then 0x0000; busy never drops.
- Reset mid-access: word store addr 0x0020, wdata 0x1234; assert rst_n low in cycle 6 -> mem_wen=0 immediately; after release req_ready=1, busy=0, no rsp_valid; mem[0x0020]=0x34 and mem[0x0021] unchanged.
